// File: rtl/ex_operand_stage.sv
// ID/EX operand register with immediate extension, destination select and optional
// EX/MEM and MEM/WB operand forwarding (enabled by defining EX_FORWARD_EN).
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  op,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm16,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        ex_valid,
  output logic [5:0]  ex_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] store_data,
  output logic [4:0]  ex_waddr,
  output logic        ex_we
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  logic        alusrc_d;
  logic [31:0] imm_ext_d;
  logic [4:0]  waddr_d;
  logic        we_d;

  logic        valid_q;
  logic [5:0]  op_q;
  logic [4:0]  rs_addr_q;
  logic [4:0]  rt_addr_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_q;
  logic [4:0]  waddr_q;
  logic        we_q;
  logic        alusrc_q;

  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  always_comb begin
    alusrc_d  = 1'b0;
    imm_ext_d = {16'h0000, imm16};
    waddr_d   = 5'd0;
    we_d      = 1'b0;
    case (op)
      OP_RTYPE: begin
        waddr_d = rd_addr;
        we_d    = 1'b1;
      end
      OP_ORI: begin
        alusrc_d = 1'b1;
        waddr_d  = rt_addr;
        we_d     = 1'b1;
      end
      OP_LW: begin
        alusrc_d  = 1'b1;
        imm_ext_d = {{16{imm16[15]}}, imm16};
        waddr_d   = rt_addr;
        we_d      = 1'b1;
      end
      OP_SW: begin
        alusrc_d  = 1'b1;
        imm_ext_d = {{16{imm16[15]}}, imm16};
      end
      OP_LUI: begin
        alusrc_d  = 1'b1;
        imm_ext_d = {imm16, 16'h0000};
        waddr_d   = rt_addr;
        we_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // flush beats stall; an idle ID slot (no stall) loads a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      op_q      <= 6'd0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      rs_data_q <= 32'd0;
      rt_data_q <= 32'd0;
      imm_q     <= 32'd0;
      waddr_q   <= 5'd0;
      we_q      <= 1'b0;
      alusrc_q  <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      valid_q   <= 1'b0;
      op_q      <= 6'd0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      rs_data_q <= 32'd0;
      rt_data_q <= 32'd0;
      imm_q     <= 32'd0;
      waddr_q   <= 5'd0;
      we_q      <= 1'b0;
      alusrc_q  <= 1'b0;
    end else if (!stall) begin
      valid_q   <= 1'b1;
      op_q      <= op;
      rs_addr_q <= rs_addr;
      rt_addr_q <= rt_addr;
      rs_data_q <= rs_data;
      rt_data_q <= rt_data;
      imm_q     <= imm_ext_d;
      waddr_q   <= waddr_d;
      we_q      <= we_d;
      alusrc_q  <= alusrc_d;
    end
  end

`ifdef EX_FORWARD_EN
  // nearest producer wins; register 0 is never forwarded
  assign rs_fwd = (mem_we && (mem_waddr == rs_addr_q) && (rs_addr_q != 5'd0)) ? mem_wdata :
                  (wb_we  && (wb_waddr  == rs_addr_q) && (rs_addr_q != 5'd0)) ? wb_wdata  :
                  rs_data_q;
  assign rt_fwd = (mem_we && (mem_waddr == rt_addr_q) && (rt_addr_q != 5'd0)) ? mem_wdata :
                  (wb_we  && (wb_waddr  == rt_addr_q) && (rt_addr_q != 5'd0)) ? wb_wdata  :
                  rt_data_q;
`else
  assign rs_fwd = rs_data_q;
  assign rt_fwd = rt_data_q;
  wire unused_fwd = ^{mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
                      rs_addr_q, rt_addr_q};
`endif

  assign ex_valid   = valid_q;
  assign ex_op      = op_q;
  assign alu_a      = rs_fwd;
  assign alu_b      = alusrc_q ? imm_q : rt_fwd;
  assign store_data = rt_fwd;
  assign ex_waddr   = waddr_q;
  assign ex_we      = we_q && (waddr_q != 5'd0);

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed vectors plus randomized traffic
// against an instruction-level reference model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush;
  logic [5:0]  op;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm16;
  logic        mem_we, wb_we;
  logic [4:0]  mem_waddr, wb_waddr;
  logic [31:0] mem_wdata, wb_wdata;
  logic        ex_valid, ex_we;
  logic [5:0]  ex_op;
  logic [31:0] alu_a, alu_b, store_data;
  logic [4:0]  ex_waddr;

  int checks = 0;
  int errors = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_valid(ex_valid), .ex_op(ex_op), .alu_a(alu_a), .alu_b(alu_b),
    .store_data(store_data), .ex_waddr(ex_waddr), .ex_we(ex_we)
  );

  always #5 clk = ~clk;

  // model: the instruction currently sitting in EX, kept as raw ID fields
  typedef struct {
    bit          v;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
  } ins_t;

  ins_t m;

  function automatic ins_t bubble();
    ins_t b;
    b.v = 0; b.op = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.rsd = 0; b.rtd = 0; b.imm = 0;
    return b;
  endfunction

  function automatic ins_t next_ins();
    ins_t n;
    if (flush) n = bubble();
    else if (stall) n = m;
    else if (!in_valid) n = bubble();
    else begin
      n.v = 1; n.op = op; n.rs = rs_addr; n.rt = rt_addr; n.rd = rd_addr;
      n.rsd = rs_data; n.rtd = rt_data; n.imm = imm16;
    end
    return n;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
`ifdef EX_FORWARD_EN
    if (a != 0 && mem_we && mem_waddr == a) return mem_wdata;
    if (a != 0 && wb_we && wb_waddr == a) return wb_wdata;
`endif
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic        imm_sel, wen;
    logic [31:0] ext, a, t;
    logic [4:0]  dst;
    imm_sel = (m.op == 6'h0d) || (m.op == 6'h23) || (m.op == 6'h2b) || (m.op == 6'h0f);
    if (m.op == 6'h23 || m.op == 6'h2b) ext = {{16{m.imm[15]}}, m.imm};
    else if (m.op == 6'h0f) ext = {m.imm, 16'h0};
    else ext = {16'h0, m.imm};
    if (m.op == 6'h00) begin dst = m.rd; wen = 1; end
    else if (m.op == 6'h0d || m.op == 6'h23 || m.op == 6'h0f) begin dst = m.rt; wen = 1; end
    else begin dst = 0; wen = 0; end
    a = fwd(m.rs, m.rsd);
    t = fwd(m.rt, m.rtd);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m.v});
    chk({tag, ".ex_op"}, {26'd0, ex_op}, {26'd0, m.op});
    chk({tag, ".alu_a"}, alu_a, a);
    chk({tag, ".alu_b"}, alu_b, imm_sel ? ext : t);
    chk({tag, ".store_data"}, store_data, t);
    chk({tag, ".ex_waddr"}, {27'd0, ex_waddr}, {27'd0, dst});
    chk({tag, ".ex_we"}, {31'd0, ex_we}, {31'd0, wen && dst != 0});
  endtask

  task automatic cycle();
    ins_t n;
    n = next_ins();
    @(posedge clk);
    if (reset) m = n;
    #1;
  endtask

  task automatic rand_id();
    logic [5:0] ops [7];
    ops = '{6'h00, 6'h0d, 6'h23, 6'h2b, 6'h0f, 6'h04, 6'h00};
    op = ops[$urandom_range(0, 6)];
    if ($urandom_range(0, 9) == 0) op = 6'($urandom);
    in_valid = ($urandom_range(0, 9) < 8);
    rs_addr = 5'($urandom_range(0, 7));
    rt_addr = 5'($urandom_range(0, 7));
    rd_addr = 5'($urandom_range(0, 7));
    rs_data = $urandom; rt_data = $urandom; imm16 = 16'($urandom);
  endtask

  task automatic rand_fwd();
    mem_we = 1'($urandom); wb_we = 1'($urandom);
    mem_waddr = 5'($urandom_range(0, 7)); wb_waddr = 5'($urandom_range(0, 7));
    mem_wdata = $urandom; wb_wdata = $urandom;
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [15:0] im);
    in_valid = 1; stall = 0; flush = 0;
    op = o; rs_addr = rs; rt_addr = rt; rd_addr = rd; rs_data = rsd; rt_data = rtd; imm16 = im;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    mem_we = 0; wb_we = 0; mem_waddr = 0; wb_waddr = 0; mem_wdata = 0; wb_wdata = 0;
    rand_id();
    #1 reset = 0; m = bubble();
    rand_fwd();
    #1;
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.ex_we", {31'd0, ex_we}, 32'd0);
    chk("rst.ex_waddr", {27'd0, ex_waddr}, 32'd0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_b", alu_b, 32'd0);
    cycle();
    check_all("rst_hold");
    @(negedge clk) reset = 1;
    mem_we = 0; wb_we = 0;

    set_instr(6'h0d, 5'd1, 5'd5, 5'd0, 32'h1, 32'h0, 16'hFFFF);
    cycle();
    chk("ori.alu_b", alu_b, 32'h0000FFFF);
    chk("ori.waddr", {27'd0, ex_waddr}, 32'd5);
    chk("ori.we", {31'd0, ex_we}, 32'd1);
    check_all("ori");
    set_instr(6'h23, 5'd2, 5'd6, 5'd0, 32'h100, 32'h0, 16'hFFFC);
    cycle();
    chk("lw.alu_b", alu_b, 32'hFFFFFFFC);
    check_all("lw");
    set_instr(6'h0f, 5'd0, 5'd7, 5'd0, 32'h0, 32'h0, 16'h1234);
    cycle();
    chk("lui.alu_b", alu_b, 32'h12340000);
    check_all("lui");
    set_instr(6'h00, 5'd1, 5'd2, 5'd9, 32'h5, 32'h77, 16'h0);
    cycle();
    chk("rtype.alu_b", alu_b, 32'h77);
    chk("rtype.waddr", {27'd0, ex_waddr}, 32'd9);
    chk("rtype.we", {31'd0, ex_we}, 32'd1);
    set_instr(6'h2b, 5'd1, 5'd3, 5'd8, 32'h40, 32'hAB, 16'h4);
    cycle();
    chk("sw.store_data", store_data, 32'hAB);
    chk("sw.we", {31'd0, ex_we}, 32'd0);
    chk("sw.waddr", {27'd0, ex_waddr}, 32'd0);
    set_instr(6'h00, 5'd3, 5'd0, 5'd0, 32'h9, 32'h1, 16'h0);
    cycle();
    chk("rd0.we", {31'd0, ex_we}, 32'd0);

    // forwarding priority with EX held by stall
    set_instr(6'h00, 5'd4, 5'd1, 5'd2, 32'h10, 32'h0, 16'h0);
    cycle();
    stall = 1; rand_id();
    mem_we = 1; mem_waddr = 4; mem_wdata = 32'h20;
    wb_we = 1; wb_waddr = 4; wb_wdata = 32'h30;
    #1;
`ifdef EX_FORWARD_EN
    chk("fwd.mem", alu_a, 32'h20);
`else
    chk("fwd.mem", alu_a, 32'h10);
`endif
    mem_we = 0; #1;
`ifdef EX_FORWARD_EN
    chk("fwd.wb", alu_a, 32'h30);
`else
    chk("fwd.wb", alu_a, 32'h10);
`endif
    check_all("fwd.wb_model");
    set_instr(6'h00, 5'd0, 5'd1, 5'd2, 32'h10, 32'h0, 16'h0);
    mem_we = 1; wb_we = 1; mem_waddr = 0; wb_waddr = 0;
    cycle();
    chk("fwd.zero", alu_a, 32'h10);
    mem_we = 0; wb_we = 0;

    set_instr(6'h0d, 5'd3, 5'd4, 5'd0, 32'h55, 32'h66, 16'h00F0);
    cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle();
      check_all("stall");
      chk("stall.alu_b", alu_b, 32'h000000F0);
    end
    flush = 1; rand_id(); in_valid = 1;
    cycle();
    chk("stallflush.valid", {31'd0, ex_valid}, 32'd0);
    check_all("stallflush");

    // reset asserted while stalled and flushing
    set_instr(6'h00, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 16'h0);
    cycle();
    stall = 1; flush = 1;
    #2 reset = 0; m = bubble(); #1;
    check_all("rst_mid");
    stall = 0; flush = 0;
    @(negedge clk) reset = 1;
    set_instr(6'h0d, 5'd1, 5'd2, 5'd0, 32'h3, 32'h4, 16'h8);
    cycle();
    check_all("post_rst");

    for (int i = 0; i < 400; i++) begin
      rand_id();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rand_fwd();
      cycle();
      check_all("rand");
      rand_fwd(); #1;
      check_all("rand_fwd");
      if ($urandom_range(0, 49) == 0) begin
        #1 reset = 0; m = bubble(); #1;
        check_all("rand_rst");
        #1 reset = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
